// File: rtl/yuyg_pkg.sv
// Shared definitions for the YUyG sweep self-test sequencer.
// Holds the FSM state encoding, sweep dimensions, the default expected
// F signatures and the {phase, code} layout used to identify a vector.
package yuyg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_CODES   = 16;
  localparam int NUM_VECTORS = 32;
  localparam int CODE_W      = 4;
  localparam int SIG_W       = NUM_CODES;
  localparam int CNT_W       = 6;

  // F for every ABCD code; bit i is the response to ABCD=i.
  localparam logic [SIG_W-1:0] EXP_EN0_DEFAULT = 16'h0000;
  localparam logic [SIG_W-1:0] EXP_EN1_DEFAULT = 16'h0DD0;

  // Vector identifier: phase is the en value, code is ABCD (bit3=A).
  typedef struct packed {
    logic              phase;
    logic [CODE_W-1:0] code;
  } vec_id_t;

  localparam int VEC_ID_W = $bits(vec_id_t);

  function automatic logic is_last_vector(input vec_id_t v);
    return v.phase && (v.code == {CODE_W{1'b1}});
  endfunction

endpackage

// File: rtl/yuyg_sig_capture.sv
// Response capture for the YUyG sweep.
// Stores each sampled F bit into the signature of its enable phase,
// compares it against the expected signature, counts mismatches and
// latches the identity of the first mismatching vector.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   clear         zero all results (sweep start)
//   sample        strobe: f_in belongs to vector {phase, code}
//   phase, code   identity of the vector being sampled
//   f_in          F response of the block under test
//   sig_en0/1     captured signatures per phase
//   mismatch_cnt  number of mismatching vectors
//   fail_valid    at least one mismatch seen
//   first_fail    {phase, code} of the first mismatch
module yuyg_sig_capture
  import yuyg_pkg::*;
#(
  parameter logic [SIG_W-1:0] EXP_EN0 = EXP_EN0_DEFAULT,
  parameter logic [SIG_W-1:0] EXP_EN1 = EXP_EN1_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                sample,
  input  logic                phase,
  input  logic [CODE_W-1:0]   code,
  input  logic                f_in,
  output logic [SIG_W-1:0]    sig_en0,
  output logic [SIG_W-1:0]    sig_en1,
  output logic [CNT_W-1:0]    mismatch_cnt,
  output logic                fail_valid,
  output logic [VEC_ID_W-1:0] first_fail
);

  logic    exp_bit;
  logic    miss;
  vec_id_t cur_id;

  always_comb begin
    exp_bit = phase ? EXP_EN1[code] : EXP_EN0[code];
    miss    = (f_in != exp_bit);
    cur_id  = '{phase: phase, code: code};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sig_en0      <= '0;
      sig_en1      <= '0;
      mismatch_cnt <= '0;
      fail_valid   <= 1'b0;
      first_fail   <= '0;
    end else if (sample) begin
      if (phase) begin
        sig_en1[code] <= f_in;
      end else begin
        sig_en0[code] <= f_in;
      end
      // At most 32 samples per sweep, so 6 bits never wrap.
      if (miss) begin
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          first_fail <= cur_id;
        end
      end
    end
  end

endmodule

// File: rtl/yuyg_sweep_bist.sv
// Self-test sequencer for the YUyG decoder function block.
// Sweeps {en, ABCD} through all 32 vectors (en=0 codes 0..15, then en=1
// codes 0..15), holds each vector SETTLE+1 cycles, samples F on the
// following cycle and hands the sample to the signature capture.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         single-cycle sweep request (ignored while busy)
//   f_in          F from the YUyG block
//   en_out        YUyG en
//   abcd_out      YUyG A,B,C,D (bit3=A, bit0=D)
//   busy, done    sweep in progress / complete (done held until restart)
//   pass          with done: no mismatches
//   sig_en0/1, mismatch_cnt, fail_valid, first_fail   sweep results
module yuyg_sweep_bist
  import yuyg_pkg::*;
#(
  parameter int unsigned      SETTLE  = 2,
  parameter logic [SIG_W-1:0] EXP_EN0 = EXP_EN0_DEFAULT,
  parameter logic [SIG_W-1:0] EXP_EN1 = EXP_EN1_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                f_in,
  output logic                en_out,
  output logic [CODE_W-1:0]   abcd_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [SIG_W-1:0]    sig_en0,
  output logic [SIG_W-1:0]    sig_en1,
  output logic [CNT_W-1:0]    mismatch_cnt,
  output logic                fail_valid,
  output logic [VEC_ID_W-1:0] first_fail
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  state_t     state;
  state_t     next_state;
  logic [3:0] settle_cnt;
  vec_id_t    vec;

  logic       clear;
  logic       load_cnt;
  logic       sample;
  logic       advance;

  // Next-state and control strobes.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    load_cnt   = 1'b0;
    sample     = 1'b0;
    advance    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state = ST_HOLD;
          clear      = 1'b1;
          load_cnt   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (settle_cnt == 4'd0) begin
          next_state = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (is_last_vector(vec)) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_HOLD;
          advance    = 1'b1;
          load_cnt   = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, settle counter and applied vector. The vector only moves on
  // the SAMPLE->HOLD transition, so it stays on the pins through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      vec        <= '0;
    end else begin
      state <= next_state;
      if (load_cnt) begin
        settle_cnt <= SETTLE_INIT;
      end else if (state == ST_HOLD && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (clear) begin
        vec <= '0;
      end else if (advance) begin
        vec <= vec + VEC_ID_W'(1);
      end
    end
  end

  yuyg_sig_capture #(
    .EXP_EN0 (EXP_EN0),
    .EXP_EN1 (EXP_EN1)
  ) u_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample       (sample),
    .phase        (vec.phase),
    .code         (vec.code),
    .f_in         (f_in),
    .sig_en0      (sig_en0),
    .sig_en1      (sig_en1),
    .mismatch_cnt (mismatch_cnt),
    .fail_valid   (fail_valid),
    .first_fail   (first_fail)
  );

  always_comb begin
    en_out   = vec.phase;
    abcd_out = vec.code;
    busy     = (state == ST_HOLD) || (state == ST_SAMPLE);
    done     = (state == ST_DONE);
    pass     = done && (mismatch_cnt == '0);
  end

endmodule

// File: tb/tb_yuyg_sweep_bist.sv
// Bench for yuyg_sweep_bist: a SETTLE=2 instance fed by a golden YUyG
// model or by a stuck F, and a SETTLE=0 instance fed by the golden model.
// Each start pushes the expected sweep result; monitors compare it when
// done rises.
module tb_yuyg_sweep_bist;

  typedef struct {
    int          lat;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [5:0]  mc;
    logic        fv;
    logic [4:0]  ff;
    logic        ps;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT A (SETTLE=2)
  logic        rst_n_a, start_a, f_a, en_a, busy_a, done_a, pass_a, fv_a;
  logic [3:0]  abcd_a;
  logic [15:0] sig0_a, sig1_a;
  logic [5:0]  mc_a;
  logic [4:0]  ff_a;
  // DUT B (SETTLE=0)
  logic        rst_n_b, start_b, f_b, en_b, busy_b, done_b, pass_b, fv_b;
  logic [3:0]  abcd_b;
  logic [15:0] sig0_b, sig1_b;
  logic [5:0]  mc_b;
  logic [4:0]  ff_b;

  int f_mode = 0;  // 0 golden, 1 stuck-at-1, 2 stuck-at-0

  // F = (A xor B)(C + D') gated by the enable.
  function automatic logic golden(input logic en, input logic [3:0] v);
    return en & (v[3] ^ v[2]) & (v[1] | ~v[0]);
  endfunction

  always_comb begin
    case (f_mode)
      1:       f_a = 1'b1;
      2:       f_a = 1'b0;
      default: f_a = golden(en_a, abcd_a);
    endcase
    f_b = golden(en_b, abcd_b);
  end

  yuyg_sweep_bist #(.SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .f_in(f_a),
    .en_out(en_a), .abcd_out(abcd_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .sig_en0(sig0_a), .sig_en1(sig1_a),
    .mismatch_cnt(mc_a), .fail_valid(fv_a), .first_fail(ff_a)
  );

  yuyg_sweep_bist #(.SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .f_in(f_b),
    .en_out(en_b), .abcd_out(abcd_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .sig_en0(sig0_b), .sig_en1(sig1_b),
    .mismatch_cnt(mc_b), .fail_valid(fv_b), .first_fail(ff_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   start_cyc_a = 0;
  int   start_cyc_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic [15:0] s0, input logic [15:0] s1,
                              input logic [5:0] mc, input logic fv, input logic [4:0] ff,
                              input logic ps);
    exp_t e;
    e.lat = lat; e.s0 = s0; e.s1 = s1; e.mc = mc; e.fv = fv; e.ff = ff; e.ps = ps;
    return e;
  endfunction

  // Monitors: compare on the rising edge of done, sampled at negedge.
  logic done_prev_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done_a && !done_prev_a) begin
      check("a_done_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_latency", 32'(cyc - start_cyc_a), 32'(e.lat));
        check("a_sig_en0", 32'(sig0_a), 32'(e.s0));
        check("a_sig_en1", 32'(sig1_a), 32'(e.s1));
        check("a_mismatch_cnt", 32'(mc_a), 32'(e.mc));
        check("a_fail_valid", 32'(fv_a), 32'(e.fv));
        check("a_first_fail", 32'(ff_a), 32'(e.ff));
        check("a_pass", 32'(pass_a), 32'(e.ps));
        check("a_busy_at_done", 32'(busy_a), 32'd0);
        check("a_last_vector", 32'({en_a, abcd_a}), 32'h1F);
      end
    end
    done_prev_a = done_a;
  end

  logic done_prev_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done_b && !done_prev_b) begin
      check("b_done_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_latency", 32'(cyc - start_cyc_b), 32'(e.lat));
        check("b_sig_en0", 32'(sig0_b), 32'(e.s0));
        check("b_sig_en1", 32'(sig1_b), 32'(e.s1));
        check("b_mismatch_cnt", 32'(mc_b), 32'(e.mc));
        check("b_fail_valid", 32'(fv_b), 32'(e.fv));
        check("b_pass", 32'(pass_b), 32'(e.ps));
      end
    end
    done_prev_b = done_b;
  end

  task automatic go_a(input exp_t e, input bit expect_done);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_cyc_a = cyc;
    if (expect_done) q_a.push_back(e);
  endtask

  task automatic go_b(input exp_t e);
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    start_cyc_b = cyc;
    q_b.push_back(e);
  endtask

  task automatic drain_a(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (q_a.size() == 0) break;
    end
    check("a_drain", 32'(q_a.size()), 32'd0);
  endtask

  task automatic drain_b(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (q_b.size() == 0) break;
    end
    check("b_drain", 32'(q_b.size()), 32'd0);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_pass"}, 32'(pass_a), 32'd0);
    check({tag, "_vector"}, 32'({en_a, abcd_a}), 32'd0);
    check({tag, "_sig_en0"}, 32'(sig0_a), 32'd0);
    check({tag, "_sig_en1"}, 32'(sig1_a), 32'd0);
    check({tag, "_mismatch_cnt"}, 32'(mc_a), 32'd0);
    check({tag, "_fail_valid"}, 32'(fv_a), 32'd0);
    check({tag, "_first_fail"}, 32'(ff_a), 32'd0);
  endtask

  exp_t e_gold2, e_one, e_zero, e_gold0;

  initial begin
    e_gold2 = mk(128, 16'h0000, 16'h0DD0, 6'd0,  1'b0, 5'b0_0000, 1'b1);
    e_one   = mk(128, 16'hFFFF, 16'hFFFF, 6'd26, 1'b1, 5'b0_0000, 1'b0);
    e_zero  = mk(128, 16'h0000, 16'h0000, 6'd6,  1'b1, 5'b1_0100, 1'b0);
    e_gold0 = mk(64,  16'h0000, 16'h0DD0, 6'd0,  1'b0, 5'b0_0000, 1'b1);

    rst_n_a = 1'b0; rst_n_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_a("reset");
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    // Golden sweep, with a start pulse while busy that must be ignored.
    f_mode = 0;
    go_a(e_gold2, 1'b1);
    check("a_busy_after_start", 32'(busy_a), 32'd1);
    repeat (20) @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    drain_a(200);
    repeat (5) @(negedge clk);
    check("a_done_held", 32'(done_a), 32'd1);

    // F stuck at 1; restart from DONE clears results on the start edge.
    f_mode = 1;
    go_a(e_one, 1'b1);
    check("a_restart_done_low", 32'(done_a), 32'd0);
    check("a_restart_sig_en1_clr", 32'(sig1_a), 32'd0);
    check("a_restart_vector", 32'({en_a, abcd_a}), 32'd0);
    drain_a(200);

    // F stuck at 0; prior stuck-at-1 results must be wiped.
    f_mode = 2;
    go_a(e_zero, 1'b1);
    check("a_restart_sig_en0_clr", 32'(sig0_a), 32'd0);
    check("a_restart_mc_clr", 32'(mc_a), 32'd0);
    check("a_restart_fv_clr", 32'(fv_a), 32'd0);
    drain_a(200);

    // Mid-sweep reset at cycle 50 of a stuck-at-1 sweep.
    f_mode = 1;
    go_a(e_one, 1'b0);
    while (cyc - start_cyc_a < 49) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b0;
    @(posedge clk);
    #1;
    check_idle_a("abort");
    @(negedge clk);
    rst_n_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_stays_idle_busy", 32'(busy_a), 32'd0);
    check("abort_stays_idle_done", 32'(done_a), 32'd0);
    f_mode = 0;
    go_a(e_gold2, 1'b1);
    drain_a(200);

    // SETTLE=0 instance.
    go_b(e_gold0);
    check("b_busy_after_start", 32'(busy_b), 32'd1);
    drain_b(120);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
